// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES S-box, inverse S-box and round-constant tables
package aes_pkg;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Used by the inverse-cipher datapath, not by the key schedule.
  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  localparam logic [7:0] RC [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round constant for round index n; zero once the schedule runs past round 10.
  function automatic logic [7:0] rc_byte(input logic [4:0] n);
    return (n < 5'd10) ? RC[n[3:0]] : 8'h00;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - forward AES S-box, combinational byte lookup
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] d
);

  assign d = SBOX[a];

endmodule

// File: rtl/aes_key_expand_128.sv
// rtl/aes_key_expand_128.sv - on-the-fly AES-128 key schedule, one round key per clock (optional kdone: AES_KEXP_DONE_EN)
module aes_key_expand_128
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  output logic [31:0]  wo_0,
  output logic [31:0]  wo_1,
  output logic [31:0]  wo_2,
  output logic [31:0]  wo_3
`ifdef AES_KEXP_DONE_EN
  ,
  output logic         kdone
`endif
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rcon;
  logic [3:0]  rcnt;
  logic [31:0] subw, t;
  logic [31:0] n0, n1, n2, n3;
  logic [4:0]  rcnt_inc;

  // RotWord is folded into the lane assignment of the four lookups.
  aes_sbox u_sbox_3 (.a(w3[23:16]), .d(subw[31:24]));
  aes_sbox u_sbox_2 (.a(w3[15:8]),  .d(subw[23:16]));
  aes_sbox u_sbox_1 (.a(w3[7:0]),   .d(subw[15:8]));
  aes_sbox u_sbox_0 (.a(w3[31:24]), .d(subw[7:0]));

  assign t  = subw ^ rcon;
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  // Widened so the saturated count (15) maps to a zero round constant.
  assign rcnt_inc = {1'b0, rcnt} + 5'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      w0   <= '0;
      w1   <= '0;
      w2   <= '0;
      w3   <= '0;
      rcon <= '0;
      rcnt <= '0;
    end else if (kld) begin
      w0   <= key[127:96];
      w1   <= key[95:64];
      w2   <= key[63:32];
      w3   <= key[31:0];
      rcon <= 32'h0100_0000;
      rcnt <= '0;
    end else begin
      w0   <= n0;
      w1   <= n1;
      w2   <= n2;
      w3   <= n3;
      rcon <= {rc_byte(rcnt_inc), 24'h0};
      rcnt <= (rcnt == 4'hf) ? rcnt : rcnt + 4'd1;
    end
  end

`ifdef AES_KEXP_DONE_EN
  // live marks a schedule started by a real key load, so a free-running
  // sequence after reset never raises kdone.
  logic live;

  always_ff @(posedge clk) begin
    if (!rst) begin
      live  <= 1'b0;
      kdone <= 1'b0;
    end else if (kld) begin
      live  <= 1'b1;
      kdone <= 1'b0;
    end else begin
      kdone <= live && (rcnt == 4'd9);
    end
  end
`endif

  assign wo_0 = w0;
  assign wo_1 = w1;
  assign wo_2 = w2;
  assign wo_3 = w3;

endmodule

// File: tb/tb_aes_key_expand_128.sv
// tb/tb_aes_key_expand_128.sv - directed self-checking bench for aes_key_expand_128
module tb_aes_key_expand_128;

  logic         clk;
  logic         rst;
  logic         kld;
  logic [127:0] key;
  logic [31:0]  wo_0, wo_1, wo_2, wo_3;
  logic [127:0] wo;
`ifdef AES_KEXP_DONE_EN
  logic         kdone;
`endif

  int checks;
  int failures;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_R2  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363_62636363_62636363_62636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

  aes_key_expand_128 dut (
    .clk  (clk),
    .rst  (rst),
    .kld  (kld),
    .key  (key),
    .wo_0 (wo_0),
    .wo_1 (wo_1),
    .wo_2 (wo_2),
    .wo_3 (wo_3)
`ifdef AES_KEXP_DONE_EN
    ,
    .kdone(kdone)
`endif
  );

  assign wo = {wo_0, wo_1, wo_2, wo_3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wo(input string tag, input logic [127:0] exp);
    checks++;
    assert (wo === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, wo, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_done(input string tag, input logic exp);
`ifdef AES_KEXP_DONE_EN
    check_bit(tag, kdone, exp);
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b0;
    kld = 1'b1;
    key = FIPS_KEY;

    // Reset overrides kld.
    step();
    step();
    check_wo("reset_wo", 128'h0);
    check_done("reset_kdone", 1'b0);

    // FIPS-197 key.
    rst = 1'b1;
    step();
    kld = 1'b0;
    check_wo("fips_r0", FIPS_KEY);
    step();
    check_wo("fips_r1", FIPS_R1);
    step();
    check_wo("fips_r2", FIPS_R2);
    for (int r = 3; r <= 9; r++) begin
      step();
      check_done("fips_kdone_early", 1'b0);
    end
    step();
    check_wo("fips_r10", FIPS_R10);
    check_done("fips_kdone_r10", 1'b1);
    step();
    check_done("fips_kdone_after", 1'b0);

    // All-zero key.
    kld = 1'b1;
    key = 128'h0;
    step();
    kld = 1'b0;
    check_wo("zero_r0", 128'h0);
    step();
    check_wo("zero_r1", ZERO_R1);
    for (int r = 2; r <= 9; r++) step();
    step();
    check_wo("zero_r10", ZERO_R10);
    check_done("zero_kdone_r10", 1'b1);

    // Mid-schedule reload at round 4.
    kld = 1'b1;
    key = 128'h0;
    step();
    kld = 1'b0;
    for (int r = 1; r <= 4; r++) step();
    kld = 1'b1;
    key = FIPS_KEY;
    step();
    kld = 1'b0;
    check_wo("reload_r0", FIPS_KEY);
    step();
    check_wo("reload_r1", FIPS_R1);
    for (int r = 2; r <= 9; r++) begin
      step();
      check_done("reload_no_stale_kdone", 1'b0);
    end
    step();
    check_wo("reload_r10", FIPS_R10);
    check_done("reload_kdone_r10", 1'b1);

    // Back-to-back kld for three cycles.
    kld = 1'b1;
    key = FIPS_KEY;
    for (int i = 0; i < 3; i++) begin
      step();
      check_wo("b2b_hold", FIPS_KEY);
    end
    kld = 1'b0;
    step();
    check_wo("b2b_r1", FIPS_R1);
    for (int r = 2; r <= 9; r++) step();
    step();
    check_wo("b2b_r10", FIPS_R10);

    // Run past round 10.
    for (int i = 0; i < 8; i++) begin
      step();
      check_bit("post_no_x", ^wo === 1'bx, 1'b0);
      check_done("post_kdone", 1'b0);
    end
    checks++;
    assert (dut.rcnt === 4'hf) else begin
      failures++;
      $error("FAIL post_rcnt observed=%h expected=f", dut.rcnt);
    end
    checks++;
    assert (dut.rcon === 32'h0) else begin
      failures++;
      $error("FAIL post_rcon observed=%h expected=00000000", dut.rcon);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_expand_128.md
# aes_key_expand_128

On-the-fly AES-128 key schedule generator. A load pulse captures a 128-bit cipher key. The block then produces one round key per clock (round 0 through round 10), as four 32-bit words. It feeds the round-key buffer of the AES inverse cipher and can serve any forward cipher that uses keys in FIPS-197 word order.

## Interface
- No parameters.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- kld  input  1  key load strobe; sampled each rising edge.
- key  input  128  cipher key; key[127:96] is word 0, key[31:0] is word 3.
- wo_0  output  32  round-key word 0 (registered).
- wo_1  output  32  round-key word 1 (registered).
- wo_2  output  32  round-key word 2 (registered).
- wo_3  output  32  round-key word 3 (registered).
- kdone  output  1  present only with AES_KEXP_DONE_EN (see Configuration).

## Operation
- State:
  - word registers w0..w3, which drive wo_0..wo_3;
  - rcon register (32 bits; only bits 31:24 nonzero);
  - 4-bit round counter rcnt.
- Priority at each edge: rst low, then kld, then advance.
- Reset (rst=0):
  - w0..w3 ← 0, rcon ← 0, rcnt ← 0;
  - kdone ← 0.
- Load (kld=1):
  - w0..w3 ← key words 0..3;
  - rcon ← 0x01000000, rcnt ← 0.
- Advance (otherwise):
  - subw = {S(w3[23:16]), S(w3[15:8]), S(w3[7:0]), S(w3[31:24])}. This is RotWord followed by SubWord, where S is the forward AES S-box.
  - t = subw ^ rcon.
  - w0 ← w0^t.
  - w1 ← w0^w1^t.
  - w2 ← w0^w1^w2^t.
  - w3 ← w0^w1^w2^w3^t.
  - rcnt ← rcnt+1, saturating at 15.
  - rcon[31:24] ← RC(rcnt+1), where RC(0..9) = 01,02,04,08,10,20,40,80,1b,36 and RC(≥10) = 00. Bits 23:0 are always 0.
- After round 10 the block keeps advancing with rcon=0. The resulting words are defined by the rule above but carry no meaning.
- kld asserted mid-schedule restarts from the new key immediately, with no residue from the old schedule.

## Timing
- Round key r (0..10) is on wo_* exactly r+1 cycles after the edge that sampled kld=1:
  - round 0 (the key itself) appears in the cycle following the load edge;
  - round 10 appears 10 cycles after that.
- Consecutive kld cycles keep reloading; the schedule starts after the last one.
- The S-box path is combinational within one cycle. There is no pipeline bubble and no back-pressure.
- Reset values: wo_*=0, kdone=0.

## Configuration
- Macro AES_KEXP_DONE_EN.
  - Defined:
    - adds output kdone, a registered 1-cycle pulse high exactly in the cycle wo_* holds round 10;
    - a reload or reset before that cycle suppresses the pulse.
  - Undefined: the kdone port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package aes_pkg:
  - 256-entry forward S-box constant;
  - 256-entry inverse S-box constant, for the sibling inverse-cipher datapath;
  - RC round-constant array.
- One sub-module, aes_sbox (8-bit combinational lookup from aes_pkg), instantiated four times for subw.

## Test plan
- Reset: hold rst=0 for 2 cycles with kld=1.
  - Required: wo_*=0 and kdone=0; reset overrides kld.
- FIPS-197 key: kld=1 with key=2b7e1516_28aed2a6_abf71588_09cf4f3c.
  - Round 0 = key.
  - Round 1 = a0fafe17 88542cb1 23a33939 2a6c7605.
  - Round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6; kdone pulses in that cycle (with macro).
- All-zero key: kld=1 with key=0.
  - Round 1 = 62636363 ×4.
  - Round 10 = b4ef5bcb 3e92e211 23e951cf 6f8f188e.
- Mid-schedule reload: load the zero key, then at round 4 load the FIPS key.
  - Required: the next cycle shows 2b7e1516…; round 1 of the FIPS key follows; no kdone for the abandoned schedule.
- Back-to-back kld: hold kld for 3 cycles.
  - Required: wo_* = key for those cycles; round 1 appears 1 cycle after kld drops.
- Post-round-10 run: continue 8 cycles past round 10.
  - Required: rcnt saturates and rcon=0; no X on outputs; kdone stays 0.
